// File: rtl/exmem_memwb_stage.sv
// EX/MEM and MEM/WB pipeline registers with the data-memory request/ack handshake.
// Optional abort of stuck accesses after TIMEOUT wait cycles: define DMEM_TIMEOUT_EN.
module exmem_memwb_stage #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_res,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    output logic [4:0]        exmem_rd,
    output logic              exmem_fwd_en,
    output logic [DATA_W-1:0] exmem_alu_res,
    output logic [4:0]        memwb_rd,
    output logic              memwb_reg_write,
    output logic [DATA_W-1:0] memwb_wdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_out,
    output logic              mem_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic              exmem_valid_reg;
    logic [4:0]        exmem_rd_reg;
    logic [DATA_W-1:0] exmem_alu_res_reg;
    logic [DATA_W-1:0] exmem_store_data_reg;
    logic              exmem_reg_write_reg;
    logic              exmem_mem_read_reg;
    logic              exmem_mem_write_reg;
    logic              exmem_mem_to_reg_reg;
    logic              exmem_fwd_en_reg;

    logic [4:0]        memwb_rd_reg;
    logic              memwb_reg_write_reg;
    logic [DATA_W-1:0] memwb_wdata_reg;

    logic [0:0]        state_reg;
    logic [0:0]        state_next;

    logic mem_op;
    logic pending;
    logic abort;
    logic wb_capture;

    assign mem_op     = exmem_valid_reg & (exmem_mem_read_reg | exmem_mem_write_reg);
    assign pending    = mem_op & ~dmem_ack;
    assign stall_out  = pending & ~abort;
    assign wb_capture = exmem_valid_reg & (~mem_op | dmem_ack);

    assign dmem_req   = mem_op;
    assign dmem_we    = exmem_mem_write_reg;
    assign dmem_addr  = exmem_alu_res_reg;
    assign dmem_wdata = exmem_store_data_reg;

    assign exmem_rd        = exmem_rd_reg;
    assign exmem_fwd_en    = exmem_fwd_en_reg;
    assign exmem_alu_res   = exmem_alu_res_reg;
    assign memwb_rd        = memwb_rd_reg;
    assign memwb_reg_write = memwb_reg_write_reg;
    assign memwb_wdata     = memwb_wdata_reg;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_reg;

    // The cycle in which the counter has reached TIMEOUT is itself the abort cycle.
    assign abort   = pending & (wait_cnt_reg == CNT_W'(TIMEOUT));
    assign mem_err = abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
        end else if (stall_out) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign mem_err        = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (stall_out) state_next = WAIT;
            WAIT:    if (dmem_ack | abort) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // EX/MEM holds while an access is outstanding so the memory sees stable address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_valid_reg      <= 1'b0;
            exmem_rd_reg         <= '0;
            exmem_alu_res_reg    <= '0;
            exmem_store_data_reg <= '0;
            exmem_reg_write_reg  <= 1'b0;
            exmem_mem_read_reg   <= 1'b0;
            exmem_mem_write_reg  <= 1'b0;
            exmem_mem_to_reg_reg <= 1'b0;
            exmem_fwd_en_reg     <= 1'b0;
        end else if (!stall_out) begin
            exmem_valid_reg      <= ex_valid;
            exmem_rd_reg         <= ex_rd;
            exmem_alu_res_reg    <= ex_alu_res;
            exmem_store_data_reg <= ex_store_data;
            exmem_reg_write_reg  <= ex_valid & ex_reg_write;
            exmem_mem_read_reg   <= ex_valid & ex_mem_read;
            exmem_mem_write_reg  <= ex_valid & ex_mem_write;
            exmem_mem_to_reg_reg <= ex_valid & ex_mem_to_reg;
            exmem_fwd_en_reg     <= ex_valid & ex_reg_write & ~ex_mem_to_reg & (ex_rd != 5'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memwb_rd_reg        <= '0;
            memwb_reg_write_reg <= 1'b0;
            memwb_wdata_reg     <= '0;
        end else if (wb_capture) begin
            memwb_rd_reg        <= exmem_rd_reg;
            memwb_reg_write_reg <= exmem_reg_write_reg & (exmem_rd_reg != 5'd0);
            memwb_wdata_reg     <= exmem_mem_to_reg_reg ? dmem_rdata : exmem_alu_res_reg;
        end else begin
            memwb_reg_write_reg <= 1'b0;
        end
    end

endmodule
